// File: rtl/divclk_monitor_pkg.sv
// Shared types for the divided-clock monitor: FSM state encoding, fault codes
// and the fault-priority helper.
package divclk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_PERIOD = 2'b01;
  localparam logic [1:0] FC_DUTY   = 2'b10;
  localparam logic [1:0] FC_STALL  = 2'b11;

  // A period error outranks a duty error when both are present.
  function automatic logic [1:0] meas_fault_code(input logic period_ok, input logic duty_ok);
    logic [1:0] code;
    if (!period_ok) begin
      code = FC_PERIOD;
    end else if (!duty_ok) begin
      code = FC_DUTY;
    end else begin
      code = FC_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/divclk_monitor_sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall pulse generator.
// Reusable for any asynchronous 1-bit input; pulses lag the input by 3 clocks.
module divclk_monitor_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Next-state for the synchronizer chain and the edge pulses.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
    fall_d  = ~sync2_q & prev_q;
  end

  // Synchronizer and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/divclk_monitor.sv
// Divided-clock monitor: measures period and high time of clk_in in clk cycles,
// declares lock after LOCK_N good periods and latches sticky period/duty/stall faults.
module divclk_monitor #(
  parameter int DIV     = 32,
  parameter int TOL     = 1,
  parameter int LOCK_N  = 4,
  parameter int TIMEOUT = 4 * DIV,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
);
  import divclk_monitor_pkg::*;

  localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] TOL_C  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_N);

  function automatic logic in_tol(input logic [CNT_W-1:0] val, input logic [CNT_W-1:0] ref_val);
    logic [CNT_W-1:0] diff;
    if (val >= ref_val) begin
      diff = val - ref_val;
    end else begin
      diff = ref_val - val;
    end
    return (diff <= TOL_C);
  endfunction

  logic rise_s, fall_s;

  divclk_monitor_sync_edge u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (clk_in),
    .rise (rise_s),
    .fall (fall_s)
  );

  state_e           state_q, state_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;

  logic       meas_s, stall_s;
  logic [1:0] ev_code_s;

  // The first rise after IDLE only starts the count; later rises are measurements.
  // A rise landing on the timeout cycle still counts as an edge.
  always_comb begin
    meas_s    = rise_s && (state_q != IDLE);
    stall_s   = (cnt_q == TMO_C) && !rise_s && (state_q != FAULT);
    ev_code_s = meas_fault_code(in_tol(cnt_q, DIV_C), in_tol(hi_lat_q, HALF_C));
  end

  // Saturating period counter, high-time latch and reported measurement.
  always_comb begin
    cnt_d       = cnt_q;
    hi_lat_d    = hi_lat_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = meas_s;
    if (rise_s) begin
      cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt_q == TMO_C) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (fall_s) begin
      hi_lat_d = cnt_q;
    end else begin
      hi_lat_d = hi_lat_q;
    end
    if (meas_s) begin
      period_d    = cnt_q;
      high_time_d = hi_lat_q;
    end else begin
      period_d    = period_q;
      high_time_d = high_time_q;
    end
  end

  // Lock/fault state machine; status outputs are registered with the state.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    code_d     = code_q;
    case (state_q)
      IDLE: begin
        if (stall_s) begin
          state_d = FAULT;
          code_d  = FC_STALL;
        end else if (rise_s) begin
          state_d    = MEAS;
          good_cnt_d = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      MEAS: begin
        if (stall_s) begin
          state_d = FAULT;
          code_d  = FC_STALL;
        end else if (meas_s && (ev_code_s == FC_NONE)) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if ((good_cnt_q + 4'd1) == LOCK_C) begin
            state_d = LOCKED;
          end else begin
            state_d = MEAS;
          end
        end else if (meas_s) begin
          good_cnt_d = 4'd0;
        end else begin
          state_d = MEAS;
        end
      end
      LOCKED: begin
        if (stall_s) begin
          state_d = FAULT;
          code_d  = FC_STALL;
        end else if (meas_s && (ev_code_s != FC_NONE)) begin
          state_d = FAULT;
          code_d  = ev_code_s;
        end else begin
          state_d = LOCKED;
        end
      end
      FAULT: begin
        // A fault arriving with clear wins and refreshes the code.
        if (clear && meas_s && (ev_code_s != FC_NONE)) begin
          code_d = ev_code_s;
        end else if (clear) begin
          state_d    = IDLE;
          code_d     = FC_NONE;
          good_cnt_d = 4'd0;
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        state_d    = IDLE;
        code_d     = FC_NONE;
        good_cnt_d = 4'd0;
      end
    endcase
    locked_d = (state_d == LOCKED);
    fault_d  = (state_d == FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      good_cnt_q  <= 4'd0;
      code_q      <= FC_NONE;
      cnt_q       <= {CNT_W{1'b0}};
      hi_lat_q    <= {CNT_W{1'b0}};
      period_q    <= {CNT_W{1'b0}};
      high_time_q <= {CNT_W{1'b0}};
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      hi_lat_q    <= hi_lat_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign fault_code   = code_q;

endmodule

// File: tb/tb_divclk_monitor.sv
// Directed self-checking bench for divclk_monitor with DIV=32, DIV=2 and DIV=512 instances.
module tb_divclk_monitor;

  typedef struct {
    logic [11:0] period;
    logic [11:0] high;
    logic        locked;
    logic        fault;
    logic [1:0]  code;
  } strobe_t;

  logic clk;
  logic rst;
  logic clear;
  logic clk_in0, clk_in2, clk_in512;

  logic [11:0] period0, high0, period2, high2, period512, high512;
  logic        valid0, locked0, fault0;
  logic        valid2, locked2, fault2;
  logic        valid512, locked512, fault512;
  logic [1:0]  code0, code2, code512;

  strobe_t q0[$];
  strobe_t q2[$];
  strobe_t q512[$];

  int checks = 0;
  int errors = 0;

  divclk_monitor dut0 (
    .clk(clk), .rst(rst), .clk_in(clk_in0), .clear(clear),
    .period(period0), .high_time(high0), .period_valid(valid0),
    .locked(locked0), .fault(fault0), .fault_code(code0)
  );

  divclk_monitor #(.DIV(2)) dut2 (
    .clk(clk), .rst(rst), .clk_in(clk_in2), .clear(clear),
    .period(period2), .high_time(high2), .period_valid(valid2),
    .locked(locked2), .fault(fault2), .fault_code(code2)
  );

  divclk_monitor #(.DIV(512)) dut512 (
    .clk(clk), .rst(rst), .clk_in(clk_in512), .clear(clear),
    .period(period512), .high_time(high512), .period_valid(valid512),
    .locked(locked512), .fault(fault512), .fault_code(code512)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and log every period_valid strobe.
  task automatic step();
    strobe_t s;
    @(negedge clk);
    if (valid0) begin
      s.period = period0; s.high = high0; s.locked = locked0; s.fault = fault0; s.code = code0;
      q0.push_back(s);
    end
    if (valid2) begin
      s.period = period2; s.high = high2; s.locked = locked2; s.fault = fault2; s.code = code2;
      q2.push_back(s);
    end
    if (valid512) begin
      s.period = period512; s.high = high512; s.locked = locked512; s.fault = fault512; s.code = code512;
      q512.push_back(s);
    end
  endtask

  task automatic drive_in(input int which, input logic v);
    case (which)
      0:       clk_in0 = v;
      2:       clk_in2 = v;
      default: clk_in512 = v;
    endcase
  endtask

  // One clk_in period: hi cycles high then lo cycles low; clear pulses on high step clr_at.
  task automatic run_period(input int hi, input int lo, input int which, input int clr_at);
    drive_in(which, 1'b1);
    for (int i = 0; i < hi; i++) begin
      if (i == clr_at) clear = 1'b1;
      step();
      clear = 1'b0;
    end
    drive_in(which, 1'b0);
    repeat (lo) step();
  endtask

  task automatic relock();
    run_period(16, 16, 0, 5);
    repeat (6) run_period(16, 16, 0, -1);
  endtask

  initial begin
    int bad;
    int n;
    rst = 1'b1; clear = 1'b0;
    clk_in0 = 1'b0; clk_in2 = 1'b0; clk_in512 = 1'b0;
    #2 rst = 1'b0;
    step(); step();
    check_eq("rst_outputs", {period0, high0, valid0, locked0, fault0, code0}, 32'd0);
    rst = 1'b1;

    // Clean 32-cycle clock: lock on the 4th strobe.
    q0.delete();
    repeat (6) run_period(16, 16, 0, -1);
    check_eq("a_strobes", q0.size(), 32'd5);
    bad = 0;
    foreach (q0[i]) if (q0[i].period != 12'd32 || q0[i].high != 12'd16 || q0[i].fault) bad++;
    check_eq("a_all_32_16", bad, 32'd0);
    check_eq("a_locked3", q0[2].locked, 32'd0);
    check_eq("a_locked4", q0[3].locked, 32'd1);
    check_eq("a_locked5", q0[4].locked, 32'd1);

    // Clear while locked is ignored; then a 34-cycle period faults with code 01.
    q0.delete();
    run_period(16, 16, 0, 5);
    run_period(17, 17, 0, -1);
    repeat (3) run_period(16, 16, 0, -1);
    check_eq("b_strobes", q0.size(), 32'd5);
    check_eq("b_clear_ignored", q0[1].locked, 32'd1);
    check_eq("b_bad_period", q0[2].period, 32'd34);
    check_eq("b_bad_high", q0[2].high, 32'd17);
    check_eq("b_bad_status", {q0[2].locked, q0[2].fault, q0[2].code}, 32'b0101);
    check_eq("b_after_period", q0[4].period, 32'd32);
    check_eq("b_after_status", {q0[4].locked, q0[4].fault, q0[4].code}, 32'b0101);

    // Clear from FAULT, relock, then a duty error.
    run_period(16, 16, 0, 5);
    check_eq("c_fault_cleared", {fault0, code0}, 32'd0);
    q0.delete();
    repeat (6) run_period(16, 16, 0, -1);
    check_eq("c_strobes", q0.size(), 32'd5);
    check_eq("c_first_fault", q0[0].fault, 32'd0);
    check_eq("c_locked3", q0[2].locked, 32'd0);
    check_eq("c_locked4", q0[3].locked, 32'd1);
    q0.delete();
    run_period(20, 12, 0, -1);
    repeat (2) run_period(16, 16, 0, -1);
    check_eq("c_duty_high", q0[1].high, 32'd20);
    check_eq("c_duty_status", {q0[1].locked, q0[1].fault, q0[1].code}, 32'b0110);
    check_eq("c_duty_held", {q0[2].fault, q0[2].code}, 32'b110);

    // Clear coincident with a 40-cycle bad period while in FAULT: fault wins.
    q0.delete();
    run_period(20, 20, 0, -1);
    run_period(20, 20, 0, 3);
    check_eq("d_period", q0[1].period, 32'd40);
    check_eq("d_status", {q0[1].fault, q0[1].code}, 32'b101);
    check_eq("d_still_fault", {fault0, code0}, 32'b101);

    // Stall: clk_in stops low after a rise; fault shows 132 steps after the rising input.
    relock();
    check_eq("e_locked", locked0, 32'd1);
    clk_in0 = 1'b1;
    n = 0;
    while (fault0 !== 1'b1 && n < 400) begin
      if (n == 16) clk_in0 = 1'b0;
      step();
      n++;
    end
    check_eq("e_stall_cycles", n, 32'd132);
    check_eq("e_stall_status", {locked0, fault0, code0}, 32'b0111);

    // Reset mid-lock clears outputs before the next clock edge.
    relock();
    clk_in0 = 1'b1;
    repeat (5) step();
    check_eq("f_locked_before", locked0, 32'd1);
    rst = 1'b0;
    clk_in0 = 1'b0;
    #1;
    check_eq("f_async_rst", {period0, high0, valid0, locked0, fault0, code0}, 32'd0);
    step();
    rst = 1'b1;
    q0.delete();
    repeat (6) run_period(16, 16, 0, -1);
    check_eq("f_relock3", q0[2].locked, 32'd0);
    check_eq("f_relock4", q0[3].locked, 32'd1);

    // DIV=2 instance.
    rst = 1'b0; step(); rst = 1'b1;
    q2.delete();
    repeat (6) run_period(1, 1, 2, -1);
    repeat (4) step();
    check_eq("g_strobes", q2.size(), 32'd5);
    check_eq("g_period", q2[0].period, 32'd2);
    check_eq("g_high", q2[0].high, 32'd1);
    check_eq("g_locked3", q2[2].locked, 32'd0);
    check_eq("g_locked4", {q2[3].locked, q2[3].fault}, 32'b10);

    // DIV=512 instance.
    rst = 1'b0; step(); rst = 1'b1;
    q512.delete();
    repeat (6) run_period(256, 256, 3, -1);
    check_eq("h_strobes", q512.size(), 32'd5);
    check_eq("h_period", q512[4].period, 32'd512);
    check_eq("h_high", q512[4].high, 32'd256);
    check_eq("h_locked3", q512[2].locked, 32'd0);
    check_eq("h_locked4", {q512[3].locked, q512[3].fault}, 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divclk_monitor.md
Name: divclk_monitor

Overview:
- Consumer-side checker for the divided clocks produced by the clock/reset generator (clk_2, clk_32, clk_512).
- Samples one divided clock on the 60 MHz system clock and measures its period and high time in system-clock cycles.
- Declares lock after a run of in-tolerance periods; flags period, duty and stall faults for the downstream modem/codec blocks and for debug.

Parameters:
- DIV, 32, expected period of clk_in in clk cycles; even, >= 2.
- TOL, 1, allowed ± deviation in cycles for both period and high time.
- LOCK_N, 4, consecutive good periods required to assert locked; range 1..15.
- TIMEOUT, 4*DIV, cycles without a rising edge before a stall fault is raised.
- CNT_W, 12, counter/output width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, 60 MHz.
- rst  in  1  asynchronous reset, active-low.
- clk_in  in  1  divided clock under test, treated as asynchronous.
- clear  in  1  synchronous pulse that clears a sticky fault.
- period  out  CNT_W  last measured period, in clk cycles.
- high_time  out  CNT_W  high time belonging to the reported period.
- period_valid  out  1  one-cycle strobe; period and high_time were updated this cycle.
- locked  out  1  high while in LOCKED.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 period error, 10 duty error, 11 stall/timeout.

Behaviour:
- Reset: one clk, asynchronous active-low reset (rst=0). All registers clear immediately, including synchronizer and FSM.
  - Output reset values: period=0, high_time=0, period_valid=0, locked=0, fault=0, fault_code=00.
  - State after reset is IDLE.
- Input path: clk_in passes a 2-FF synchronizer, then a registered edge detector producing rise/fall pulses. Latency from clk_in edge to pulse is 3 clk cycles, constant, so measurements are exact.
- Period counter cnt:
  - Loads 1 on a rise pulse; otherwise increments.
  - Saturates at TIMEOUT and never wraps.
- High time: on a fall pulse, hi_lat <= cnt.
- Measurement: on each rise pulse after the first since IDLE, in the same cycle:
  - period <= cnt, high_time <= hi_lat, period_valid=1.
  - Result: period = clk cycles between successive rises.
- Checks, evaluated on each measurement:
  - Period good iff |period−DIV| <= TOL.
  - Duty good iff |hi_lat−DIV/2| <= TOL.
  - If both fail, period error has priority (code 01).
- Timeout: cnt == TIMEOUT without a rise pulse, in any state except FAULT, is a stall event.
- FSM states:
  - IDLE: wait for first rise, then go to MEAS with good_cnt=0. A stall goes to FAULT with code 11.
  - MEAS: on a good measurement, good_cnt+1; when good_cnt reaches LOCK_N, go to LOCKED. On a bad measurement, good_cnt=0, stay in MEAS, no fault. A stall goes to FAULT with code 11.
  - LOCKED: locked=1. A bad measurement goes to FAULT with code 01/10; a stall goes to FAULT with code 11.
  - FAULT: fault=1, locked=0, fault_code held. period/high_time/period_valid keep updating. clear=1 returns to IDLE, fault=0, code=00, good_cnt=0.
- locked deasserts in the same cycle as the failing period_valid (registered together with the state change).
- Simultaneous events:
  - A fault event and clear in the same cycle: the fault wins (stays or enters FAULT, new code latched).
  - clear outside FAULT is ignored.
- A rise pulse in the same cycle cnt hits TIMEOUT counts as an edge, not a stall.
- Reset asserted mid-lock: outputs drop to reset values asynchronously. After release, the full lock sequence is required again.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, MEAS, LOCKED, FAULT.
  - Fault code constants: FC_NONE, FC_PERIOD, FC_DUTY, FC_STALL.
- One natural sub-module: sync_edge (2-FF synchronizer plus registered rise/fall pulse generator, 1-bit, reset to 0). It is reusable for other asynchronous inputs, such as switches.

Test Plan:
- Drive clk_in from a clock/reset-generator clk_32 output (same clk/rst), DIV=32, TOL=1, LOCK_N=4 -> every period_valid shows period=32 and high_time=16; locked=1 on the 4th good strobe; fault=0 throughout.
- After lock, insert one period of 34 cycles (17/17) -> on that strobe locked=0, fault=1, fault_code=01; later strobes report 32 while fault stays 1.
- After lock, insert a period of 32 with high time 20 -> fault_code=10. Then pulse clear -> fault=0 and IDLE; locked reasserts on the 4th good strobe after re-entry.
- After lock, hold clk_in low -> fault=1 with fault_code=11 exactly when cnt reaches 128 after the last rise pulse.
- Assert clear in the same cycle as a 40-cycle bad period while in FAULT -> fault stays 1 and the code updates to 01. Assert rst=0 mid-lock -> all outputs 0 before the next clk edge.
- DIV=2 fed from clk_2 -> period=2, high_time=1, locked after 4 good strobes; DIV=512 fed from clk_512 -> period=512, high_time=256, CNT_W=12 is sufficient.
